serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_ctrl.sv | 136 +++++++++++++
 tb/tb_serial_add_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full_adder is reused for a WIDTH-bit addition,
// one bit per clock, LSB first, with a registered carry between bit-steps.

module full_adder (
  input  logic a_in,
  input  logic b_in,
  input  logic c_in,
  output logic sum_out,
  output logic carry_out
);

  assign sum_out   = a_in ^ b_in ^ c_in;
  assign carry_out = (a_in & b_in) | (a_in & c_in) | (b_in & c_in);

endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out
);

  localparam int CNT_W = 6;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_shift_q, a_shift_d;
  logic [WIDTH-1:0] b_shift_q, b_shift_d;
  logic [WIDTH-1:0] p_shift_q, p_shift_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic             fa_sum;
  logic             fa_carry;
  logic [WIDTH-1:0] p_next;

  full_adder u_full_adder (
    .a_in      (a_shift_q[0]),
    .b_in      (b_shift_q[0]),
    .c_in      (carry_q),
    .sum_out   (fa_sum),
    .carry_out (fa_carry)
  );

  // New sum bit enters from the MSB so that after WIDTH steps bit 0 sits at the LSB.
  assign p_next = (p_shift_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));

  // Next-state and datapath update for the three-state sequencer.
  always_comb begin
    state_d   = state_q;
    a_shift_d = a_shift_q;
    b_shift_d = b_shift_q;
    p_shift_d = p_shift_q;
    carry_d   = carry_q;
    bit_cnt_d = bit_cnt_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_in) begin
          state_d   = RUN;
          a_shift_d = a_in;
          b_shift_d = b_in;
          p_shift_d = {WIDTH{1'b0}};
          carry_d   = c_in;
          bit_cnt_d = {CNT_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_shift_d = a_shift_q >> 1;
        b_shift_d = b_shift_q >> 1;
        p_shift_d = p_next;
        carry_d   = fa_carry;
        bit_cnt_d = bit_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (bit_cnt_q == LAST_BIT) begin
          state_d = DONE;
          sum_d   = p_next;
          cout_d  = fa_carry;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, all cleared asynchronously.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      a_shift_q <= {WIDTH{1'b0}};
      b_shift_q <= {WIDTH{1'b0}};
      p_shift_q <= {WIDTH{1'b0}};
      carry_q   <= 1'b0;
      bit_cnt_q <= {CNT_W{1'b0}};
      sum_q     <= {WIDTH{1'b0}};
      cout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_shift_q <= a_shift_d;
      b_shift_q <= b_shift_d;
      p_shift_q <= p_shift_d;
      carry_q   <= carry_d;
      bit_cnt_q <= bit_cnt_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
    end
  end

  assign busy_out  = (state_q == RUN);
  assign done_out  = (state_q == DONE);
  assign sum_out   = sum_q;
  assign carry_out = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and randomized checks for serial_add_ctrl at WIDTH = 8.

module tb_serial_add_ctrl;

  localparam int WIDTH = 8;

  logic             clock;
  logic             reset_n;
  logic             start_in;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             c_in;
  logic             busy_out;
  logic             done_out;
  logic [WIDTH-1:0] sum_out;
  logic             carry_out;

  int n_tests = 0;
  int n_fail  = 0;

  logic [WIDTH-1:0] prev_sum;
  logic             prev_carry;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start_in  (start_in),
    .a_in      (a_in),
    .b_in      (b_in),
    .c_in      (c_in),
    .busy_out  (busy_out),
    .done_out  (done_out),
    .sum_out   (sum_out),
    .carry_out (carry_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Caller is at a negedge. Drives start with the operands, checks 8 RUN cycles,
  // then returns at the DONE negedge after checking the result.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic [8:0] exp, input bit keep_start, input int repulse);
    start_in = 1'b1;
    a_in     = a;
    b_in     = b;
    c_in     = c;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (!keep_start && i == 0) start_in = 1'b0;
      a_in = 8'($urandom);
      b_in = 8'($urandom);
      c_in = 1'($urandom);
      if (i == repulse) begin
        start_in = 1'b1;
        a_in     = 8'hFF;
        b_in     = 8'hFF;
      end
      if (i == repulse + 1) start_in = 1'b0;
      check_eq("busy_run", {31'd0, busy_out}, 32'd1);
      check_eq("done_run", {31'd0, done_out}, 32'd0);
      check_eq("sum_hold", {24'd0, sum_out}, {24'd0, prev_sum});
      check_eq("carry_hold", {31'd0, carry_out}, {31'd0, prev_carry});
    end
    @(negedge clock);
    check_eq("done_pulse", {31'd0, done_out}, 32'd1);
    check_eq("busy_done", {31'd0, busy_out}, 32'd0);
    check_eq("sum", {24'd0, sum_out}, {24'd0, exp[7:0]});
    check_eq("carry", {31'd0, carry_out}, {31'd0, exp[8]});
    prev_sum   = exp[7:0];
    prev_carry = exp[8];
  endtask

  logic [7:0] ra, rb;
  logic       rc;
  logic [8:0] rexp;

  initial begin
    reset_n    = 1'b0;
    start_in   = 1'b0;
    a_in       = 8'h00;
    b_in       = 8'h00;
    c_in       = 1'b0;
    prev_sum   = 8'h00;
    prev_carry = 1'b0;

    repeat (2) @(negedge clock);
    check_eq("rst_busy", {31'd0, busy_out}, 32'd0);
    check_eq("rst_done", {31'd0, done_out}, 32'd0);
    check_eq("rst_sum", {24'd0, sum_out}, 32'd0);
    check_eq("rst_carry", {31'd0, carry_out}, 32'd0);
    reset_n = 1'b1;

    // Directed vectors with hand-computed results.
    @(negedge clock);
    run_op(8'h5A, 8'h3C, 1'b0, 9'h096, 1'b0, -1);
    @(negedge clock);
    check_eq("done_one_cycle", {31'd0, done_out}, 32'd0);
    check_eq("idle_after_done", {31'd0, busy_out}, 32'd0);
    run_op(8'hFF, 8'h01, 1'b0, 9'h100, 1'b0, -1);
    @(negedge clock);
    run_op(8'hFF, 8'h00, 1'b1, 9'h100, 1'b0, -1);
    @(negedge clock);
    run_op(8'h0F, 8'hF0, 1'b1, 9'h100, 1'b0, -1);
    @(negedge clock);
    run_op(8'h10, 8'h20, 1'b0, 9'h030, 1'b0, 2);
    @(negedge clock);
    check_eq("repulse_ignored", {31'd0, busy_out}, 32'd0);

    // Back-to-back with start held high: one result every 9 cycles.
    run_op(8'h01, 8'h01, 1'b0, 9'h002, 1'b1, -1);
    run_op(8'h80, 8'h80, 1'b1, 9'h101, 1'b1, -1);
    run_op(8'hAA, 8'h55, 1'b0, 9'h0FF, 1'b1, -1);
    run_op(8'hC3, 8'h3C, 1'b1, 9'h100, 1'b0, -1);
    @(negedge clock);
    check_eq("b2b_end_idle", {31'd0, busy_out}, 32'd0);

    // Reset in the middle of RUN.
    start_in = 1'b1;
    a_in     = 8'h5A;
    b_in     = 8'h3C;
    c_in     = 1'b0;
    @(negedge clock);
    start_in = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", {31'd0, busy_out}, 32'd0);
    check_eq("mid_rst_done", {31'd0, done_out}, 32'd0);
    check_eq("mid_rst_sum", {24'd0, sum_out}, 32'd0);
    check_eq("mid_rst_carry", {31'd0, carry_out}, 32'd0);
    prev_sum   = 8'h00;
    prev_carry = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check_eq("post_rst_no_done", {31'd0, done_out}, 32'd0);
      check_eq("post_rst_idle", {31'd0, busy_out}, 32'd0);
    end
    run_op(8'h01, 8'h02, 1'b0, 9'h003, 1'b0, -1);

    // Randomized operands and gaps against a reference sum.
    for (int k = 0; k < 1000; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clock);
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      rc   = 1'($urandom);
      rexp = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      run_op(ra, rb, rc, rexp, 1'b0, -1);
    end

    @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
